gate_bist_driver: RTL and testbench
===================================

Name: gate_bist_driver

Overview:
- Built-in self-test initiator for the 7-output two-input gate bank: drives its `a`/`b` inputs and checks its `y[6:0]` result vector.
- On `start`, sweeps all four input combinations, waits a settle time, compares `y` against internally computed expected values, and reports pass/fail, mismatch count, sticky failing-bit mask and first failing combination.
- Sits beside the gate bank at block level and replaces the open-loop testbench stimulus with a self-checking hardware sequencer.

Parameters:
- SETTLE_CYCLES, 1, cycles each combination is held before `y` is compared (legal range 1..15).
- LOOPS, 1, number of full 4-combination sweeps per run (legal range 1..15).
- CNT_W, 6, width of `err_count`.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising `clk`.
- start  input  1  run request, sampled only in IDLE.
- y  input  7  result vector from the gate bank.
- a  output  1  stimulus bit a to the gate bank (registered).
- b  output  1  stimulus bit b to the gate bank (registered).
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 when the last completed run had zero mismatches; held until next start.
- err_count  output  CNT_W  number of mismatching combinations in the run, saturating at all-ones.
- err_vec  output  7  sticky OR of (`y` XOR expected) over the run.
- fail_ab  output  2  {a,b} of the first mismatching combination.
- fail_valid  output  1  1 once `fail_ab` has been captured.

Behaviour:
- Interface decision: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `err_vec`=0, `fail_ab`=0, `fail_valid`=0, FSM=IDLE.
- Reset mid-run aborts the run immediately. No done pulse is produced and all outputs return to their reset values.
- Expected vector for {a,b}:
  - bit0 = ~a
  - bit1 = a&b
  - bit2 = a|b
  - bit3 = ~(a&b)
  - bit4 = ~(a|b)
  - bit5 = a^b
  - bit6 = ~(a^b)
  - Expected is computed from the registered `a`/`b` currently driven.
- Combination order within a sweep: {a,b} = 00, 01, 10, 11. Index wraps from 11 back to 00 between loops.
- FSM states: IDLE, RUN, DONE.
- IDLE + `start`=1 at edge S:
  - Enter RUN; `busy`=1.
  - `{a,b}`=00; settle counter=0; loop counter=0.
  - `err_count`, `err_vec`, `fail_valid`, `fail_ab` and `pass` are cleared to 0.
  - `done` is 0 in every state except DONE.
- RUN:
  - The settle counter increments each cycle.
  - At edge S + k·SETTLE_CYCLES (k = 1..4·LOOPS), `y` is compared with expected for the combination driven during the preceding SETTLE_CYCLES cycles.
  - On mismatch:
    - `err_count` increments, saturating at all-ones.
    - `err_vec` ORs in the differing bits.
    - If `fail_valid`=0, `fail_ab` captures the current {a,b} and `fail_valid` is set to 1.
  - If this was not the final combination, the same edge advances {a,b} to the next combination and clears the settle counter. Each combination is therefore driven for exactly SETTLE_CYCLES cycles.
  - At the final compare edge: enter DONE; `busy`=0; `a`/`b` hold 11.
  - `pass` is set to (final `err_count`==0), including the mismatch result of this last compare.
- DONE: lasts one cycle with `done`=1, then returns to IDLE. `start` is ignored in DONE.
- Latency: `done` is high in the cycle beginning at edge S + 4·LOOPS·SETTLE_CYCLES.
- `start` while `busy`=1 is ignored; there is no restart and no queuing. `start` held high re-arms on the first IDLE cycle after DONE.
- Result outputs hold their last values in IDLE until the next accepted `start`.

Test Plan:
- Correct gate model on `y`, SETTLE_CYCLES=1, LOOPS=1, start pulse at edge S:
  - `a`/`b` sequence 00, 01, 10, 11 on successive cycles.
  - `done`=1 for exactly one cycle from edge S+4.
  - `pass`=1, `err_count`=0, `err_vec`=7'h00, `fail_valid`=0.
- `y[5]` (XOR) stuck at 0 -> mismatches at 01 and 10 -> `err_count`=2, `err_vec`=7'b0100000, `fail_ab`=2'b01, `fail_valid`=1, `pass`=0.
- Every bit of `y` inverted -> `err_count`=4, `err_vec`=7'h7F, `fail_ab`=2'b00, `pass`=0.
- SETTLE_CYCLES=3, LOOPS=2, correct model:
  - Each {a,b} is held 3 cycles and the pattern repeats twice.
  - `done` at edge S+24; `busy` high for 24 cycles; `pass`=1.
- `rst_n`=0 for one edge during the third combination -> all outputs read reset values on the next cycle, no `done` pulse; a new `start` runs a clean pass.
- `start` re-pulsed while `busy`=1 (mid-sweep) -> ignored, `done` still at S+4. Then `start` held high continuously -> a second run begins in the IDLE cycle after DONE, and `err_count` is cleared at that start.

Source files
------------

// File: rtl/gate_bist_driver.sv
// Self-test sequencer for the 7-output two-input gate bank: sweeps {a,b}
// through 00..11, checks y against the expected gate outputs and reports the result.
module gate_bist_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int LOOPS         = 1,
    parameter int CNT_W         = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [6:0]       err_vec,
    output logic [1:0]       fail_ab,
    output logic             fail_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       LOOP_LAST   = 4'(LOOPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q, state_d;
    logic [1:0]       combo_q, combo_d;
    logic [3:0]       settle_q, settle_d;
    logic [3:0]       loop_q, loop_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [6:0]       err_vec_q, err_vec_d;
    logic [1:0]       fail_ab_q, fail_ab_d;
    logic             fail_valid_q, fail_valid_d;
    logic             pass_q, pass_d;

    logic       cur_a, cur_b;
    logic [6:0] exp_vec;
    logic [6:0] diff_vec;
    logic       mismatch;
    logic       compare_now;
    logic       last_combo;

    // Expected gate-bank response to the stimulus currently being driven.
    always_comb begin
        cur_a    = combo_q[1];
        cur_b    = combo_q[0];
        exp_vec  = {~(cur_a ^ cur_b), cur_a ^ cur_b, ~(cur_a | cur_b),
                    ~(cur_a & cur_b), cur_a | cur_b, cur_a & cur_b, ~cur_a};
        diff_vec = y ^ exp_vec;
        mismatch = |diff_vec;
    end

    always_comb begin
        compare_now = (state_q == RUN) && (settle_q == SETTLE_LAST);
        last_combo  = (combo_q == 2'b11) && (loop_q == LOOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            combo_q      <= 2'b00;
            settle_q     <= 4'd0;
            loop_q       <= 4'd0;
            err_count_q  <= '0;
            err_vec_q    <= 7'h00;
            fail_ab_q    <= 2'b00;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            combo_q      <= combo_d;
            settle_q     <= settle_d;
            loop_q       <= loop_d;
            err_count_q  <= err_count_d;
            err_vec_q    <= err_vec_d;
            fail_ab_q    <= fail_ab_d;
            fail_valid_q <= fail_valid_d;
            pass_q       <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (compare_now && last_combo) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sweep counters and result accumulation; results hold outside of RUN.
    always_comb begin
        combo_d      = combo_q;
        settle_d     = settle_q;
        loop_d       = loop_q;
        err_count_d  = err_count_q;
        err_vec_d    = err_vec_q;
        fail_ab_d    = fail_ab_q;
        fail_valid_d = fail_valid_q;
        pass_d       = pass_q;

        if (state_q == IDLE && start) begin
            combo_d      = 2'b00;
            settle_d     = 4'd0;
            loop_d       = 4'd0;
            err_count_d  = '0;
            err_vec_d    = 7'h00;
            fail_ab_d    = 2'b00;
            fail_valid_d = 1'b0;
            pass_d       = 1'b0;
        end else if (state_q == RUN) begin
            settle_d = settle_q + 4'd1;
            if (compare_now) begin
                if (mismatch) begin
                    if (err_count_q != CNT_MAX) begin
                        err_count_d = err_count_q + CNT_ONE;
                    end
                    err_vec_d = err_vec_q | diff_vec;
                    if (!fail_valid_q) begin
                        fail_ab_d    = combo_q;
                        fail_valid_d = 1'b1;
                    end
                end
                if (last_combo) begin
                    pass_d = (err_count_d == '0);
                end else begin
                    combo_d  = combo_q + 2'd1;
                    settle_d = 4'd0;
                    if (combo_q == 2'b11) begin
                        loop_d = loop_q + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        busy       = (state_q == RUN);
        done       = (state_q == DONE);
        a          = combo_q[1];
        b          = combo_q[0];
        pass       = pass_q;
        err_count  = err_count_q;
        err_vec    = err_vec_q;
        fail_ab    = fail_ab_q;
        fail_valid = fail_valid_q;
    end

endmodule

// File: tb/tb_gate_bist_driver.sv
// Directed self-checking bench for gate_bist_driver, with a gate-bank model
// whose outputs can be inverted or stuck at 0 to plant faults.
module tb_gate_bist_driver;

    logic clk;
    logic rst_n;

    // Instance 0: SETTLE_CYCLES=1, LOOPS=1
    logic       start0;
    logic [6:0] y0;
    logic       a0, b0, busy0, done0, pass0, fail_valid0;
    logic [5:0] err_count0;
    logic [6:0] err_vec0;
    logic [1:0] fail_ab0;
    logic [6:0] inv_mask0;
    logic [6:0] stuck_mask0;

    // Instance 1: SETTLE_CYCLES=3, LOOPS=2
    logic       start1;
    logic [6:0] y1;
    logic       a1, b1, busy1, done1, pass1, fail_valid1;
    logic [5:0] err_count1;
    logic [6:0] err_vec1;
    logic [1:0] fail_ab1;

    int total_checks;
    int bad_checks;

    function automatic logic [6:0] gateBank(input logic ga, input logic gb);
        gateBank = {~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb, ~ga};
    endfunction

    assign y0 = (gateBank(a0, b0) ^ inv_mask0) & ~stuck_mask0;
    assign y1 = gateBank(a1, b1);

    gate_bist_driver #(.SETTLE_CYCLES(1), .LOOPS(1), .CNT_W(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err_count0), .err_vec(err_vec0), .fail_ab(fail_ab0),
        .fail_valid(fail_valid0)
    );

    gate_bist_driver #(.SETTLE_CYCLES(3), .LOOPS(2), .CNT_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .err_vec(err_vec1), .fail_ab(fail_ab1),
        .fail_valid(fail_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] inv, input logic [6:0] stuck);
        inv_mask0   = inv;
        stuck_mask0 = stuck;
    endtask

    // Run one sweep on dut0 from a start pulse and check the result at S+4.
    task automatic runSweep0(input string name, input logic [5:0] exp_cnt, input logic [6:0] exp_vec,
                             input logic [1:0] exp_ab, input logic exp_valid, input logic exp_pass);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        checkOutput({name, "_ab_s0"}, 32'({a0, b0}), 32'd0);
        checkOutput({name, "_busy_s0"}, 32'(busy0), 32'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            checkOutput({name, "_ab_seq"}, 32'({a0, b0}), 32'(k));
            checkOutput({name, "_done_early"}, 32'(done0), 32'd0);
        end
        tick();
        checkOutput({name, "_done"}, 32'(done0), 32'd1);
        checkOutput({name, "_busy_end"}, 32'(busy0), 32'd0);
        checkOutput({name, "_ab_hold"}, 32'({a0, b0}), 32'd3);
        checkOutput({name, "_err_count"}, 32'(err_count0), 32'(exp_cnt));
        checkOutput({name, "_err_vec"}, 32'(err_vec0), 32'(exp_vec));
        checkOutput({name, "_fail_valid"}, 32'(fail_valid0), 32'(exp_valid));
        if (exp_valid) checkOutput({name, "_fail_ab"}, 32'(fail_ab0), 32'(exp_ab));
        checkOutput({name, "_pass"}, 32'(pass0), 32'(exp_pass));
        tick();
        checkOutput({name, "_done_gone"}, 32'(done0), 32'd0);
        checkOutput({name, "_pass_held"}, 32'(pass0), 32'(exp_pass));
    endtask

    initial begin
        int busy_cycles;
        int done_at;
        int done_pulses;
        total_checks = 0;
        bad_checks   = 0;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        applyStimulus(7'h00, 7'h00);
        tick();
        tick();
        rst_n = 1'b1;

        $display("[TB] reset values");
        checkOutput("rst_ab", 32'({a0, b0}), 32'd0);
        checkOutput("rst_busy", 32'(busy0), 32'd0);
        checkOutput("rst_done", 32'(done0), 32'd0);
        checkOutput("rst_pass", 32'(pass0), 32'd0);
        checkOutput("rst_cnt", 32'(err_count0), 32'd0);
        checkOutput("rst_vec", 32'(err_vec0), 32'd0);
        checkOutput("rst_fail", 32'({fail_ab0, fail_valid0}), 32'd0);

        $display("[TB] clean sweep");
        runSweep0("clean", 6'd0, 7'h00, 2'b00, 1'b0, 1'b1);

        $display("[TB] xor output stuck at 0");
        applyStimulus(7'h00, 7'b0100000);
        runSweep0("xor0", 6'd2, 7'b0100000, 2'b01, 1'b1, 1'b0);

        $display("[TB] all outputs inverted");
        applyStimulus(7'h7F, 7'h00);
        runSweep0("inv", 6'd4, 7'h7F, 2'b00, 1'b1, 1'b0);

        $display("[TB] settle 3, two loops");
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        busy_cycles = 0;
        done_at     = -1;
        for (int t = 0; t < 40 && done_at < 0; t++) begin
            if (busy1) begin
                busy_cycles++;
                checkOutput("s3_ab_seq", 32'({a1, b1}), 32'((t / 3) % 4));
            end
            if (done1) done_at = t;
            if (done_at < 0) tick();
        end
        checkOutput("s3_done_at", 32'(done_at), 32'd24);
        checkOutput("s3_busy_cycles", 32'(busy_cycles), 32'd24);
        checkOutput("s3_pass", 32'(pass1), 32'd1);
        checkOutput("s3_cnt", 32'(err_count1), 32'd0);

        $display("[TB] reset during third combination");
        applyStimulus(7'h00, 7'h00);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        checkOutput("abort_ab_third", 32'({a0, b0}), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort_busy", 32'(busy0), 32'd0);
        checkOutput("abort_ab", 32'({a0, b0}), 32'd0);
        checkOutput("abort_done", 32'(done0), 32'd0);
        checkOutput("abort_results", 32'({pass0, err_count0, err_vec0, fail_ab0, fail_valid0}), 32'd0);
        done_pulses = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (done0) done_pulses++;
        end
        checkOutput("abort_no_done", 32'(done_pulses), 32'd0);
        runSweep0("after_abort", 6'd0, 7'h00, 2'b00, 1'b0, 1'b1);

        $display("[TB] start while busy, then held start");
        applyStimulus(7'h7F, 7'h00);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        checkOutput("restart_done_s3", 32'(done0), 32'd0);
        tick();
        checkOutput("restart_done_s4", 32'(done0), 32'd1);
        checkOutput("restart_cnt", 32'(err_count0), 32'd4);
        applyStimulus(7'h00, 7'h00);
        start0 = 1'b1;
        tick();
        checkOutput("held_idle_busy", 32'(busy0), 32'd0);
        checkOutput("held_idle_done", 32'(done0), 32'd0);
        checkOutput("held_idle_cnt", 32'(err_count0), 32'd4);
        tick();
        start0 = 1'b0;
        checkOutput("held_rearm_busy", 32'(busy0), 32'd1);
        checkOutput("held_rearm_cnt", 32'(err_count0), 32'd0);
        checkOutput("held_rearm_pass", 32'(pass0), 32'd0);
        tick();
        tick();
        tick();
        tick();
        checkOutput("held_done", 32'(done0), 32'd1);
        checkOutput("held_pass", 32'(pass0), 32'd1);
        checkOutput("held_cnt", 32'(err_count0), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
